wb_write_port: RTL

- Writeback-side producer for the ID-stage register file write port (`reg_write` / `data_write`).
- Collects completed results from the EX (ALU) path and the MEM (load-return) path into an in-order write queue.
- Retires at most one register write per cycle.
- Optionally exposes a youngest-match bypass so ID can see results still in flight.

---
 rtl/wb_write_port.sv | 114 +++++++++++
 1 files changed

// File: rtl/wb_write_port.sv
// wb_write_port: in-order writeback queue feeding the register-file write port.
// Define WB_FWD_EN to enable the youngest-match bypass lookup on q_rs1/q_rs2.
`ifndef REG_NUM_WIDTH
`define REG_NUM_WIDTH 5
`endif
`ifndef COMMON_WIDTH
`define COMMON_WIDTH 32
`endif
module wb_write_port #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alu_valid,
  input  logic [`REG_NUM_WIDTH-1:0] alu_rd,
  input  logic [`COMMON_WIDTH-1:0]  alu_data,
  input  logic                      mem_valid,
  input  logic [`REG_NUM_WIDTH-1:0] mem_rd,
  input  logic [`COMMON_WIDTH-1:0]  mem_data,
  output logic                      wb_ready,
  output logic [`REG_NUM_WIDTH-1:0] reg_write,
  output logic [`COMMON_WIDTH-1:0]  data_write,
  input  logic [`REG_NUM_WIDTH-1:0] q_rs1,
  input  logic [`REG_NUM_WIDTH-1:0] q_rs2,
  output logic                      fwd1_hit,
  output logic [`COMMON_WIDTH-1:0]  fwd1_data,
  output logic                      fwd2_hit,
  output logic [`COMMON_WIDTH-1:0]  fwd2_data
);
  localparam int RW = `REG_NUM_WIDTH;
  localparam int DW = `COMMON_WIDTH;
  localparam int IW = $clog2(DEPTH);
  logic [RW-1:0] rd_q [DEPTH];
  logic [RW-1:0] rd_d [DEPTH];
  logic [DW-1:0] dat_q [DEPTH];
  logic [DW-1:0] dat_d [DEPTH];
  logic [IW-1:0] head_q, head_d, tail_q, tail_d, slot1;
  logic [CNT_W-1:0] count_q, count_d;
  logic [RW-1:0] reg_write_q, reg_write_d;
  logic [DW-1:0] data_write_q, data_write_d;
  logic m_push, a_push, pop;
  function automatic logic [IW-1:0] inc(input logic [IW-1:0] p);
    return (p == IW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign wb_ready   = count_q <= CNT_W'(DEPTH - 2);
  assign reg_write  = reg_write_q;
  assign data_write = data_write_q;
  always_comb begin
    m_push       = wb_ready && mem_valid && mem_rd != '0;
    a_push       = wb_ready && alu_valid && alu_rd != '0;
    pop          = count_q != '0;
    rd_d         = rd_q;
    dat_d        = dat_q;
    slot1        = m_push ? inc(tail_q) : tail_q;
    if (m_push) begin
      rd_d[tail_q]  = mem_rd;
      dat_d[tail_q] = mem_data;
    end
    if (a_push) begin
      rd_d[slot1]  = alu_rd;
      dat_d[slot1] = alu_data;
    end
    tail_d       = a_push ? inc(slot1) : slot1;
    head_d       = pop ? inc(head_q) : head_q;
    count_d      = count_q + CNT_W'(m_push) + CNT_W'(a_push) - CNT_W'(pop);
    reg_write_d  = pop ? rd_q[head_q] : '0;
    data_write_d = pop ? dat_q[head_q] : data_write_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      reg_write_q  <= '0;
      data_write_q <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      reg_write_q  <= reg_write_d;
      data_write_q <= data_write_d;
    end
  end
  always_ff @(posedge clk) begin
    rd_q  <= rd_d;
    dat_q <= dat_d;
  end
`ifdef WB_FWD_EN
  // Oldest source first so each later match overrides: the final value is the youngest.
  function automatic logic [DW:0] lookup(input logic [RW-1:0] q);
    logic [DW:0] r;
    int idx;
    r = (reg_write_q == q) ? {1'b1, data_write_q} : '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = int'(head_q) + i;
      if (idx >= DEPTH) idx -= DEPTH;
      if (i < int'(count_q) && rd_q[IW'(idx)] == q) r = {1'b1, dat_q[IW'(idx)]};
    end
    if (m_push && mem_rd == q) r = {1'b1, mem_data};
    if (a_push && alu_rd == q) r = {1'b1, alu_data};
    return (q == '0) ? '0 : r;
  endfunction
  assign {fwd1_hit, fwd1_data} = lookup(q_rs1);
  assign {fwd2_hit, fwd2_data} = lookup(q_rs2);
`else
  logic unused_q_rs;
  assign unused_q_rs = ^{q_rs1, q_rs2};
  assign fwd1_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_hit  = 1'b0;
  assign fwd2_data = '0;
`endif
endmodule
